// File: rtl/firmware_loader.sv
// Boot-stage loader: packs a little-endian byte stream into 32-bit words, writes them
// sequentially into the instruction ROM, then pulses the processor reset and enables it.
module firmware_loader #(
    parameter int ADDR_WIDTH = 6,
    parameter int ROM_DEPTH  = 64,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  halt,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic                  rom_write_enable,
    output logic [ADDR_WIDTH-1:0] rom_write_address,
    output logic [WORD_WIDTH-1:0] rom_write_data,
    output logic                  cpu_reset,
    output logic                  cpu_enable,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, RELEASE, RUN} state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(ROM_DEPTH);

    state_t                state, next_state;
    logic [1:0]            byte_idx;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0]   count;
    logic [WORD_WIDTH-9:0] data;
    logic                  xfer, last_word, load_start, bad_start;

    assign s_ready   = (state == LOAD);
    assign xfer      = s_valid && s_ready;
    assign last_word = ({1'b0, addr} == (count - 1'b1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // halt overrides every transition, including a start request in IDLE
    always_comb begin
        next_state = state;
        load_start = 1'b0;
        bad_start  = 1'b0;
        if (halt) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (word_count != '0 && word_count <= DEPTH_LIM) begin
                            next_state = LOAD;
                            load_start = 1'b1;
                        end else begin
                            bad_start = 1'b1;
                        end
                    end
                end
                LOAD:    if (xfer && byte_idx == 2'd3) next_state = WRITE;
                WRITE:   next_state = last_word ? RELEASE : LOAD;
                RELEASE: next_state = RUN;
                RUN:     next_state = RUN;
                default: next_state = IDLE;
            endcase
        end
    end

    // Outputs are registered from next_state so they line up with the state they describe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_idx          <= '0;
            addr              <= '0;
            count             <= '0;
            data              <= '0;
            error             <= 1'b0;
            rom_write_enable  <= 1'b0;
            rom_write_address <= '0;
            rom_write_data    <= '0;
            cpu_reset         <= 1'b0;
            cpu_enable        <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            rom_write_enable  <= (next_state == WRITE);
            rom_write_address <= (next_state == WRITE) ? addr : '0;
            rom_write_data    <= (next_state == WRITE) ? {s_data, data} : '0;
            cpu_reset         <= (next_state == RELEASE);
            cpu_enable        <= (next_state == RUN);
            done              <= (next_state == RUN);
            busy              <= (next_state == LOAD) || (next_state == WRITE) ||
                                 (next_state == RELEASE);

            if (bad_start) error <= 1'b1;

            if (load_start) begin
                error    <= 1'b0;
                count    <= word_count;
                addr     <= '0;
                byte_idx <= '0;
                data     <= '0;
            end

            if (halt) begin
                byte_idx <= '0;
            end else if (state == LOAD && xfer) begin
                byte_idx <= byte_idx + 1'b1;
                case (byte_idx)
                    2'd0:    data[7:0]   <= s_data;
                    2'd1:    data[15:8]  <= s_data;
                    2'd2:    data[23:16] <= s_data;
                    default: ;
                endcase
            end else if (state == WRITE && !last_word) begin
                addr <= addr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_firmware_loader.sv
// Self-checking bench for firmware_loader: table of load scenarios with random images,
// a write-log scoreboard, plus hand sequences for halt mid-load and reset in RUN.
module tb_firmware_loader;

    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          halt = 1'b0;
    logic [AW:0]   word_count = '0;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = '0;
    logic          s_ready, rom_write_enable, cpu_reset, cpu_enable, busy, done, error;
    logic [AW-1:0] rom_write_address;
    logic [31:0]   rom_write_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          wc;
        int          gap;
        bit          fixed;
        bit          illegal;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    vec_t        vecs[7];
    wr_t         wlog[$];
    logic [7:0]  img[256];
    logic [31:0] exp_word[64];
    logic [7:0]  fixed_bytes[8];

    firmware_loader #(.ADDR_WIDTH(AW), .ROM_DEPTH(DEPTH), .WORD_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .halt(halt), .word_count(word_count),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .rom_write_enable(rom_write_enable), .rom_write_address(rom_write_address),
        .rom_write_data(rom_write_data), .cpu_reset(cpu_reset), .cpu_enable(cpu_enable),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Write log and processor-control exclusivity, sampled mid-cycle
    always @(negedge clk) begin
        if (reset && rom_write_enable) wlog.push_back('{int'(rom_write_address), rom_write_data});
        checkOutput("cpu_excl", {31'd0, cpu_reset && cpu_enable}, 32'd0);
    end

    task automatic applyStimulus(input int wc);
        word_count = (AW + 1)'(wc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulseHalt();
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        checkOutput("halt_busy", {31'd0, busy}, 0);
        checkOutput("halt_cpu_enable", {31'd0, cpu_enable}, 0);
        checkOutput("halt_done", {31'd0, done}, 0);
        checkOutput("halt_s_ready", {31'd0, s_ready}, 0);
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap, input bit chk_gap);
        int n = 0;
        s_valid = 1'b1;
        s_data = b;
        while (s_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL byte_timeout actual=s_ready_low expected=s_ready_high");
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_data = 8'($urandom);
        for (int k = 0; k < gap; k++) begin
            if (chk_gap) checkOutput("gap_s_ready", {31'd0, s_ready}, 1);
            @(negedge clk);
        end
    endtask

    task automatic fillImage(input int n, input bit fixed);
        for (int i = 0; i < n * 4; i++) img[i] = fixed ? fixed_bytes[i % 8] : 8'($urandom);
        for (int i = 0; i < n; i++)
            exp_word[i] = img[4*i] + img[4*i+1] * 32'd256 + img[4*i+2] * 32'd65536 +
                          img[4*i+3] * 32'd16777216;
    endtask

    task automatic runLoad(input vec_t v);
        int n = v.wc;
        int g;
        fillImage(n, v.fixed);
        wlog.delete();
        applyStimulus(n);
        checkOutput("start_error", {31'd0, error}, 0);
        checkOutput("start_busy", {31'd0, busy}, 1);
        for (int i = 0; i < n * 4; i++) begin
            g = (v.gap < 0) ? int'($urandom_range(0, 3)) : v.gap;
            if (i == n * 4 - 1) g = 0;
            sendByte(img[i], g, (i % 4) != 3);
        end
        checkOutput("last_we", {31'd0, rom_write_enable}, 1);
        checkOutput("last_addr", {26'd0, rom_write_address}, n - 1);
        @(negedge clk);
        checkOutput("rel_cpu_reset", {31'd0, cpu_reset}, 1);
        checkOutput("rel_cpu_enable", {31'd0, cpu_enable}, 0);
        checkOutput("rel_busy", {31'd0, busy}, 1);
        @(negedge clk);
        checkOutput("run_cpu_enable", {31'd0, cpu_enable}, 1);
        checkOutput("run_done", {31'd0, done}, 1);
        checkOutput("run_cpu_reset", {31'd0, cpu_reset}, 0);
        checkOutput("run_busy", {31'd0, busy}, 0);
        checkOutput("write_count", wlog.size(), n);
        for (int i = 0; i < wlog.size() && i < n; i++) begin
            checkOutput("write_addr", wlog[i].addr, i);
            checkOutput("write_data", wlog[i].data, exp_word[i]);
        end
        if (v.fixed && wlog.size() >= 2) begin
            checkOutput("fixed_word0", wlog[0].data, v.w0);
            checkOutput("fixed_word1", wlog[1].data, v.w1);
        end
    endtask

    initial begin
        fixed_bytes = '{8'h0D, 8'h00, 8'h22, 8'h20, 8'h0F, 8'h00, 8'h43, 8'h20};
        vecs[0] = '{2, 0, 1'b1, 1'b0, 32'h2022000D, 32'h2043000F};
        vecs[1] = '{2, 3, 1'b1, 1'b0, 32'h2022000D, 32'h2043000F};
        vecs[2] = '{0, 0, 1'b0, 1'b1, 32'h0, 32'h0};
        vecs[3] = '{DEPTH + 1, 0, 1'b0, 1'b1, 32'h0, 32'h0};
        vecs[4] = '{1, 1, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[5] = '{DEPTH, 0, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[6] = '{5, -1, 1'b0, 1'b0, 32'h0, 32'h0};

        @(negedge clk);
        checkOutput("rst_busy", {31'd0, busy}, 0);
        checkOutput("rst_done", {31'd0, done}, 0);
        checkOutput("rst_error", {31'd0, error}, 0);
        checkOutput("rst_cpu", {30'd0, cpu_reset, cpu_enable}, 0);
        checkOutput("rst_we", {31'd0, rom_write_enable}, 0);
        checkOutput("rst_s_ready", {31'd0, s_ready}, 0);
        reset = 1'b1;
        @(negedge clk);

        // halt and start together: halt wins, nothing starts
        halt = 1'b1;
        applyStimulus(2);
        halt = 1'b0;
        checkOutput("halt_prio_busy", {31'd0, busy}, 0);

        for (int t = 0; t < 7; t++) begin
            pulseHalt();
            if (vecs[t].illegal) begin
                wlog.delete();
                applyStimulus(vecs[t].wc);
                checkOutput("illegal_error", {31'd0, error}, 1);
                checkOutput("illegal_busy", {31'd0, busy}, 0);
                repeat (3) @(negedge clk);
                checkOutput("illegal_s_ready", {31'd0, s_ready}, 0);
                checkOutput("illegal_writes", wlog.size(), 0);
            end else begin
                runLoad(vecs[t]);
            end
        end

        // halt after word 0 plus two bytes of word 1
        pulseHalt();
        fillImage(3, 1'b0);
        wlog.delete();
        applyStimulus(3);
        for (int i = 0; i < 6; i++) sendByte(img[i], 0, 1'b1);
        pulseHalt();
        repeat (3) @(negedge clk);
        checkOutput("halt_writes", wlog.size(), 1);
        if (wlog.size() >= 1) begin
            checkOutput("halt_w0_addr", wlog[0].addr, 0);
            checkOutput("halt_w0_data", wlog[0].data, exp_word[0]);
        end
        runLoad(vecs[4]);

        // start in RUN is ignored; async reset drops enable without a clock edge
        applyStimulus(2);
        repeat (2) @(negedge clk);
        checkOutput("run_start_done", {31'd0, done}, 1);
        checkOutput("run_start_busy", {31'd0, busy}, 0);
        checkOutput("run_start_writes", wlog.size(), 1);
        #2 reset = 1'b0;
        #1;
        checkOutput("async_cpu_enable", {31'd0, cpu_enable}, 0);
        checkOutput("async_done", {31'd0, done}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_busy", {31'd0, busy}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
